nf_ahb_router_pm: RTL
=====================

// Module: nf_ahb_router_pm
// PURPOSE
//  Parametrised AHB-Lite single-master router/interconnect: decodes haddr against a per-slave base/mask map,
//  drives hsel_s, registers the data-phase owner and muxes hrdata/hready/hresp back to the master.
//  Includes a built-in default slave that returns a two-cycle AHB ERROR for unmapped active transfers,
//  plus a saturating error counter. Sits between the core's AHB master port and the memory/peripheral slaves.
// PARAMETERS
//  SLV_N      4                                   number of slaves (1..16)
//  ADDR_W     32                                  address width
//  DATA_W     32                                  data width
//  SLV_BASE   {0x0003_0000,..,0x0000_0000}        packed SLV_N*ADDR_W; slave i base = SLV_BASE[i*ADDR_W +: ADDR_W]
//  SLV_MASK   {4{0xFFFF_0000}}                    packed SLV_N*ADDR_W; slave i mask, same slicing
//  ERR_CNT_W  8                                   width of err_cnt
// PORTS
//  hclk         in   1               clock, all logic on rising edge
//  hresetn      in   1               reset, synchronous, active-low
//  haddr        in   ADDR_W          master address (address phase)
//  htrans       in   2               master transfer type
//  hwrite       in   1               master write enable
//  hwdata       in   DATA_W          master write data (data phase)
//  hrdata       out  DATA_W          read data to master
//  hready       out  1               transfer done / bus ready to master
//  hresp        out  1               0 OKAY, 1 ERROR
//  hsel_s       out  SLV_N           per-slave select (address phase)
//  haddr_s      out  SLV_N*ADDR_W    haddr broadcast
//  htrans_s     out  SLV_N*2         htrans broadcast
//  hwrite_s     out  SLV_N           hwrite broadcast
//  hwdata_s     out  SLV_N*DATA_W    hwdata broadcast
//  hready_s     out  SLV_N           hready broadcast (slave HREADY input)
//  hrdata_s     in   SLV_N*DATA_W    per-slave read data
//  hresp_s      in   SLV_N           per-slave response
//  hreadyout_s  in   SLV_N           per-slave HREADYOUT
//  err_cnt      out  ERR_CNT_W       count of ERROR responses issued by the default slave, saturating
// BEHAVIOUR
//  - Decode (comb): match[i] = ((haddr & MASK[i]) == BASE[i]); on overlap, lowest index wins (one-hot).
//    active = htrans[1] (NONSEQ/SEQ). hsel_s[i] = match_onehot[i] & active. Unmapped = active & ~|match.
//    IDLE/BUSY never selects a slave and never triggers the default slave.
//  - Broadcasts are pure wires; hready_s[i] = hready.
//  - Data-phase owner sel_ff (SLV_N one-hot + dflt bit) loads {hsel_s, unmapped} only when hready==1.
//    Holds while hready==0 (wait states).
//  - Mux (comb on sel_ff): slave i owner -> hrdata = hrdata_s[i], hready = hreadyout_s[i], hresp = hresp_s[i].
//    No owner -> hready = 1, hresp = 0, hrdata = 0. Default-slave owner -> driven by FSM, hrdata = 0.
//  - Default-slave FSM: DS_IDLE, DS_ERR1, DS_ERR2.
//    DS_IDLE: if unmapped & hready -> DS_ERR1.
//    DS_ERR1: hready = 0, hresp = 1; -> DS_ERR2 unconditionally.
//    DS_ERR2: hready = 1, hresp = 1; -> DS_ERR1 if unmapped (new unmapped accepted this cycle), else DS_IDLE.
//    No wait states beyond this; an ERROR is always exactly 2 cycles.
//  - err_cnt increments by 1 in each DS_ERR2 cycle and saturates at 2^ERR_CNT_W-1. Cleared only by reset.
//  - Latency: zero-wait OKAY for mapped slaves with hreadyout=1, i.e. response in the cycle after the address phase.
//  - Reset (hresetn==0 at a clock edge): sel_ff = 0, FSM = DS_IDLE, err_cnt = 0.
//    While hresetn is low, hsel_s is forced to 0.
//    Outputs in the first cycle after reset: hready = 1, hresp = 0, hrdata = 0.
//    Reset mid-transfer or mid-ERROR abandons it; no ERROR phase resumes.
//  - A slave asserting hresp with hreadyout=0 is passed through unchanged; this block does not enforce slave protocol.
// TESTING
//  1 NONSEQ read at 0x0001_0004, hreadyout_s[1]=1, hrdata_s[1]=0xDEADBEEF -> hsel_s=4'b0010; next cycle hrdata=0xDEADBEEF, hready=1, hresp=0.
//  2 Write to slave 2 with hreadyout_s[2] low for 3 cycles -> hready=0 for 3 cycles; sel_ff held; next address not re-latched until hready=1.
//  3 NONSEQ at 0x8000_0000 (unmapped) -> hsel_s=0; then hready=0/hresp=1, then hready=1/hresp=1; err_cnt 0->1.
//  4 Back-to-back NONSEQ to slave 0 then slave 3, both zero-wait -> data-phase mux switches 0->3 on consecutive cycles; no bubble.
//  5 hresetn low during DS_ERR1 -> next cycle hready=1, hresp=0, err_cnt=0, FSM DS_IDLE.
//  6 ERR_CNT_W=2, five unmapped transfers -> err_cnt = 1, 2, 3, 3, 3 (saturates); IDLE to unmapped address -> OKAY, no count.

Source files
------------

// File: rtl/nf_ahb_router_pm.sv
// nf_ahb_router_pm: AHB-Lite single-master address decoder, response mux and default error slave
// with a saturating count of ERROR responses issued for unmapped transfers.
module nf_ahb_router_pm #(
    parameter int SLV_N = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [SLV_N*ADDR_W-1:0] SLV_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [SLV_N*ADDR_W-1:0] SLV_MASK = {4{32'hFFFF_0000}},
    parameter int ERR_CNT_W = 8
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [ADDR_W-1:0]       haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [DATA_W-1:0]       hwdata,
    output logic [DATA_W-1:0]       hrdata,
    output logic                    hready,
    output logic                    hresp,
    output logic [SLV_N-1:0]        hsel_s,
    output logic [SLV_N*ADDR_W-1:0] haddr_s,
    output logic [SLV_N*2-1:0]      htrans_s,
    output logic [SLV_N-1:0]        hwrite_s,
    output logic [SLV_N*DATA_W-1:0] hwdata_s,
    output logic [SLV_N-1:0]        hready_s,
    input  logic [SLV_N*DATA_W-1:0] hrdata_s,
    input  logic [SLV_N-1:0]        hresp_s,
    input  logic [SLV_N-1:0]        hreadyout_s,
    output logic [ERR_CNT_W-1:0]    err_cnt
);
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
    ds_state_t state, state_nxt;
    logic [SLV_N-1:0] match, onehot;
    logic [SLV_N:0] sel_ff;
    logic unmapped;

    always_comb begin
        match = '0;
        for (int i = 0; i < SLV_N; i++)
            match[i] = (haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
    end

    // isolate the lowest set bit so overlapping windows resolve to the lowest index
    assign onehot   = match & (~match + 1'b1);
    assign hsel_s   = (hresetn && htrans[1]) ? onehot : '0;
    assign unmapped = hresetn & htrans[1] & ~|match;

    assign haddr_s  = {SLV_N{haddr}};
    assign htrans_s = {SLV_N{htrans}};
    assign hwrite_s = {SLV_N{hwrite}};
    assign hwdata_s = {SLV_N{hwdata}};
    assign hready_s = {SLV_N{hready}};

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        for (int i = 0; i < SLV_N; i++)
            if (sel_ff[i]) begin
                hrdata = hrdata_s[i*DATA_W +: DATA_W];
                hready = hreadyout_s[i];
                hresp  = hresp_s[i];
            end
        if (sel_ff[SLV_N]) begin
            hready = state != DS_ERR1;
            hresp  = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == DS_IDLE ? ((unmapped && hready) ? DS_ERR1 : DS_IDLE) :
                    state == DS_ERR1 ? DS_ERR2 : (unmapped ? DS_ERR1 : DS_IDLE);
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            sel_ff  <= '0;
            state   <= DS_IDLE;
            err_cnt <= '0;
        end else begin
            if (hready)
                sel_ff <= {unmapped, hsel_s};
            state <= state_nxt;
            if (state == DS_ERR2 && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
